// File: rtl/adc_channel_scheduler_if.sv
// Bus between the ADC front-end / result consumers and the channel scheduler.
// The slave side is the scheduler; the master side drives mask, samples and reads.
interface adc_channel_scheduler_if;
    logic [15:0] ch_enable;
    logic [3:0]  channel;
    logic        new_sample;
    logic [9:0]  sample;
    logic [3:0]  sample_channel;
    logic [3:0]  rd_sel;
    logic [9:0]  rd_data;
    logic [15:0] ch_valid;
    logic        sample_strobe;
    logic [3:0]  sample_ch;
    logic [9:0]  sample_out;
    logic        timeout_err;
    logic [3:0]  err_ch;
    logic        err_clr;

    modport slave (
        input  ch_enable, new_sample, sample, sample_channel, rd_sel, err_clr,
        output channel, rd_data, ch_valid, sample_strobe, sample_ch, sample_out,
               timeout_err, err_ch
    );

    modport master (
        output ch_enable, new_sample, sample, sample_channel, rd_sel, err_clr,
        input  channel, rd_data, ch_valid, sample_strobe, sample_ch, sample_out,
               timeout_err, err_ch
    );
endinterface

// File: rtl/adc_channel_scheduler.sv
// Round-robin ADC channel sequencer: selects the mux channel, drops settling
// samples, captures one sample per visit into a result bank, flags stalled visits.
module adc_channel_scheduler #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DISCARD = 1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    adc_channel_scheduler_if.slave    bus
);

    localparam int unsigned CH_W   = 4;
    localparam int unsigned SMP_W  = 10;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BANK_N = 16;
    localparam logic [MASK_W-1:0] CH_MASK = MASK_W'((64'd1 << NUM_CH) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_DISCARD,
        ST_WAIT
    } state_t;

    localparam state_t ST_VISIT = (DISCARD > 0) ? ST_DISCARD : ST_WAIT;

    state_t             r_state;
    logic [CH_W-1:0]    r_channel;
    logic [CH_W-1:0]    r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [CH_W-1:0]    r_disc;
    logic [SMP_W-1:0]   r_bank [BANK_N];
    logic [MASK_W-1:0]  r_ch_valid;
    logic               r_strobe;
    logic [CH_W-1:0]    r_sample_ch;
    logic [SMP_W-1:0]   r_sample_out;
    logic               r_err;
    logic [CH_W-1:0]    r_err_ch;

    logic [MASK_W-1:0]  w_mask;
    logic               w_qual;
    logic               w_cur_en;
    logic               w_timeout;
    logic               w_found;
    logic [CH_W-1:0]    w_next_ch;
    logic [CH_W-1:0]    w_idx;

    assign w_mask    = bus.ch_enable & CH_MASK;
    assign w_qual    = bus.new_sample && (bus.sample_channel == r_channel);
    assign w_cur_en  = w_mask[r_channel];
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    // First enabled channel after the last-served one, wrapping back to it.
    always_comb begin
        w_found   = 1'b0;
        w_next_ch = r_last;
        w_idx     = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_W'((32'(r_last) + k) % NUM_CH);
            if (!w_found && w_mask[w_idx]) begin
                w_found   = 1'b1;
                w_next_ch = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_channel    <= '0;
            r_last       <= CH_W'(NUM_CH - 1);
            r_cnt        <= '0;
            r_disc       <= '0;
            r_ch_valid   <= '0;
            r_strobe     <= 1'b0;
            r_sample_ch  <= '0;
            r_sample_out <= '0;
            r_err        <= 1'b0;
            r_err_ch     <= '0;
            for (int i = 0; i < BANK_N; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            r_strobe <= 1'b0;
            // A timeout raised in this same cycle overrides the clear below.
            if (bus.err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (|w_mask) begin
                        r_state <= ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    r_cnt  <= '0;
                    r_disc <= '0;
                    if (w_found) begin
                        r_channel <= w_next_ch;
                        r_state   <= ST_VISIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DISCARD, ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!w_cur_en) begin
                        r_last  <= r_channel;
                        r_state <= ST_SEEK;
                    end else if (w_qual && (r_state == ST_DISCARD)) begin
                        if (r_disc == CH_W'(DISCARD - 1)) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= '0;
                        end else begin
                            r_disc <= r_disc + CH_W'(1);
                        end
                    end else if (w_qual) begin
                        r_bank[r_channel]     <= bus.sample;
                        r_sample_out          <= bus.sample;
                        r_sample_ch           <= r_channel;
                        r_ch_valid[r_channel] <= 1'b1;
                        r_strobe              <= 1'b1;
                        r_last                <= r_channel;
                        r_state               <= ST_SEEK;
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_err_ch <= r_channel;
                        r_last   <= r_channel;
                        r_state  <= ST_SEEK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (32'(bus.rd_sel) < NUM_CH) begin
            bus.rd_data = r_bank[bus.rd_sel];
        end
    end

    assign bus.channel       = r_channel;
    assign bus.ch_valid      = r_ch_valid;
    assign bus.sample_strobe = r_strobe;
    assign bus.sample_ch     = r_sample_ch;
    assign bus.sample_out    = r_sample_out;
    assign bus.timeout_err   = r_err;
    assign bus.err_ch        = r_err_ch;

endmodule
